// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer feeding inst_fetch; tags each fetched word with its address.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned RESET_VECTOR = 0,
   parameter int unsigned PC_STEP      = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 halt_req,
   input  logic                 redirect_valid,
   input  logic [WORD_SIZE-1:0] redirect_target,
   input  logic                 stall,
   input  logic                 busy,
   output logic [WORD_SIZE-1:0] ptr,
   output logic                 fetch_enable,
   output logic [WORD_SIZE-1:0] pc_tag,
   output logic                 inst_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0]          fetch_count,
   output logic [31:0]          stall_count,
`endif
   output logic [1:0]           state_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] STALL  = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;

   localparam logic [WORD_SIZE-1:0] RstVec = WORD_SIZE'(RESET_VECTOR);
   localparam logic [WORD_SIZE-1:0] Step   = WORD_SIZE'(PC_STEP);

   logic [1:0]           state_q, state_d;
   logic [WORD_SIZE-1:0] ptr_q, ptr_d;
   logic                 fetch_enable_q;
   logic [WORD_SIZE-1:0] pc_tag_q;
   logic                 inst_valid_q;
   logic                 hold;
   logic                 accepted;

   assign hold = stall | busy;

   // A request held off by halt or replaced by a redirect is never accepted, so the
   // wrong-path word is squashed and ptr keeps the next un-fetched address.
   assign accepted = (state_q == FETCH) & fetch_enable_q & ~hold & ~halt_req & ~redirect_valid;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               ptr_d   = RstVec;
            end
         end
         FETCH, STALL: begin
            if (redirect_valid) begin
               ptr_d = redirect_target;
            end else if (accepted) begin
               ptr_d = ptr_q + Step;
            end
            if (halt_req) begin
               state_d = HALTED;
            end else if (hold) begin
               state_d = STALL;
            end else begin
               state_d = FETCH;
            end
         end
         HALTED: begin
            if (start && !halt_req) begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         ptr_q          <= RstVec;
         fetch_enable_q <= 1'b0;
         pc_tag_q       <= '0;
         inst_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         fetch_enable_q <= (state_d == FETCH);
         pc_tag_q       <= ptr_q;
         inst_valid_q   <= accepted;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_q, stall_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         if (accepted && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if ((state_q == STALL) && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

   assign ptr          = ptr_q;
   assign fetch_enable = fetch_enable_q;
   assign pc_tag       = pc_tag_q;
   assign inst_valid   = inst_valid_q;
   assign state_o      = state_q;

endmodule
